// File: rtl/mem_line_ctrl.sv
// Memory-side stage that serves one arbiter request at a time against a single-port word SRAM.
// A write is a single-word SRAM access; a read is a burst of word reads assembled into one line.
module mem_line_ctrl #(
    parameter int ADDR_SIZE       = 16,
    parameter int WRITE_DATA_SIZE = 32,
    parameter int READ_DATA_SIZE  = 512,
    parameter int WORD_SIZE       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read_en,
    input  logic [ADDR_SIZE-1:0]       mem_read_addr,
    input  logic                       mem_write_en,
    input  logic [ADDR_SIZE-1:0]       mem_write_addr,
    input  logic [WRITE_DATA_SIZE-1:0] mem_write_data,
    output logic [READ_DATA_SIZE-1:0]  mem_read_data,
    output logic                       read_valid,
    output logic                       write_done,
    output logic                       sram_en,
    output logic                       sram_we,
    output logic [ADDR_SIZE-1:0]       sram_addr,
    output logic [WORD_SIZE-1:0]       sram_wdata,
    input  logic [WORD_SIZE-1:0]       sram_rdata
);

    localparam int WORDS  = READ_DATA_SIZE / WORD_SIZE;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (WRITE_DATA_SIZE != WORD_SIZE || (READ_DATA_SIZE % WORD_SIZE) != 0) begin : g_bad_params
        $error("mem_line_ctrl: WRITE_DATA_SIZE must equal WORD_SIZE and READ_DATA_SIZE must be a multiple of WORD_SIZE");
    end

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_DRAIN,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BEAT_W-1:0]         cap_slot;
    logic [READ_DATA_SIZE-1:0] mem_read_data_q, mem_read_data_d;
    logic                      read_valid_q, read_valid_d;
    logic                      write_done_q, write_done_d;
    logic                      sram_en_q, sram_en_d;
    logic                      sram_we_q, sram_we_d;
    logic [ADDR_SIZE-1:0]      sram_addr_q, sram_addr_d;
    logic [WORD_SIZE-1:0]      sram_wdata_q, sram_wdata_d;

    // sram_addr_q doubles as the latched address; read data lags its issue by one beat.
    assign cap_slot = beat_q - BEAT_W'(1);

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        mem_read_data_d = mem_read_data_q;
        read_valid_d    = 1'b0;
        write_done_d    = 1'b0;
        sram_en_d       = sram_en_q;
        sram_we_d       = sram_we_q;
        sram_addr_d     = sram_addr_q;
        sram_wdata_d    = sram_wdata_q;

        case (state_q)
            IDLE: begin
                sram_en_d = 1'b0;
                sram_we_d = 1'b0;
                if (mem_write_en) begin
                    state_d      = WRITE;
                    sram_en_d    = 1'b1;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = mem_write_addr;
                    sram_wdata_d = mem_write_data;
                end else if (mem_read_en) begin
                    state_d     = READ_ISSUE;
                    beat_d      = '0;
                    sram_en_d   = 1'b1;
                    sram_we_d   = 1'b0;
                    sram_addr_d = mem_read_addr;
                end
            end
            WRITE: begin
                sram_en_d    = 1'b0;
                sram_we_d    = 1'b0;
                write_done_d = 1'b1;
                state_d      = DONE;
            end
            READ_ISSUE: begin
                if (beat_q != '0) begin
                    mem_read_data_d[int'(cap_slot)*WORD_SIZE +: WORD_SIZE] = sram_rdata;
                end
                if (beat_q == BEAT_W'(WORDS - 1)) begin
                    sram_en_d = 1'b0;
                    state_d   = READ_DRAIN;
                end else begin
                    beat_d      = beat_q + BEAT_W'(1);
                    sram_addr_d = sram_addr_q + ADDR_SIZE'(1);
                end
            end
            READ_DRAIN: begin
                mem_read_data_d[(WORDS-1)*WORD_SIZE +: WORD_SIZE] = sram_rdata;
                read_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                sram_en_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                sram_en_d = 1'b0;
                sram_we_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            mem_read_data_q <= '0;
            read_valid_q    <= 1'b0;
            write_done_q    <= 1'b0;
            sram_en_q       <= 1'b0;
            sram_we_q       <= 1'b0;
            sram_addr_q     <= '0;
            sram_wdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            mem_read_data_q <= mem_read_data_d;
            read_valid_q    <= read_valid_d;
            write_done_q    <= write_done_d;
            sram_en_q       <= sram_en_d;
            sram_we_q       <= sram_we_d;
            sram_addr_q     <= sram_addr_d;
            sram_wdata_q    <= sram_wdata_d;
        end
    end

    assign mem_read_data = mem_read_data_q;
    assign read_valid    = read_valid_q;
    assign write_done    = write_done_q;
    assign sram_en       = sram_en_q;
    assign sram_we       = sram_we_q;
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;

endmodule

// File: doc/mem_line_ctrl.md
Name: mem_line_ctrl

Overview:
- Memory-side stage directly downstream of the client arbiter. It serves one arbiter request at a time against a single-port, word-wide SRAM.
- A write is a single-word SRAM write. A read is a burst of sequential word reads assembled into one wide line.
- It returns read_valid and write_done pulses, which the arbiter consumes as upstream_read_valid and upstream_write_done.

Parameters:
- ADDR_SIZE, 16, word address width on both the arbiter side and the SRAM side.
- WRITE_DATA_SIZE, 32, arbiter write data width; must equal WORD_SIZE.
- READ_DATA_SIZE, 512, assembled read line width; must be an integer multiple of WORD_SIZE.
- WORD_SIZE, 32, SRAM word width.
- Derived: WORDS = READ_DATA_SIZE/WORD_SIZE = 16, the beat count per read.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mem_read_en  in  1  read request; level, held until read_valid.
- mem_read_addr  in  ADDR_SIZE  word address of the line's first word.
- mem_write_en  in  1  write request; level, held until write_done.
- mem_write_addr  in  ADDR_SIZE  write word address.
- mem_write_data  in  WRITE_DATA_SIZE  write data.
- mem_read_data  out  READ_DATA_SIZE  assembled line; word i in bits [i*WORD_SIZE +: WORD_SIZE].
- read_valid  out  1  one-cycle pulse: mem_read_data is complete.
- write_done  out  1  one-cycle pulse: the write has been committed to the SRAM.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable; qualified by sram_en.
- sram_addr  out  ADDR_SIZE  SRAM word address.
- sram_wdata  out  WORD_SIZE  SRAM write data.
- sram_rdata  in  WORD_SIZE  SRAM read data; valid exactly one cycle after a read access (sram_en=1, sram_we=0).

Behaviour:
- Reset: all outputs are registered and clear to 0 (mem_read_data, read_valid, write_done, sram_en, sram_we, sram_addr, sram_wdata). The FSM goes to IDLE and the beat counters clear.
- FSM states: IDLE, WRITE, READ_ISSUE, READ_DRAIN, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If mem_write_en=1, go to WRITE; this applies even when mem_read_en=1 (write has priority; the read stays pending because the requester holds it).
  - Else if mem_read_en=1, go to READ_ISSUE.
  - Address and data are latched at acceptance. Later changes on the inputs are ignored until the next acceptance.
- WRITE: drive sram_en=1, sram_we=1, sram_addr and sram_wdata from the latched values for exactly one cycle, then go to DONE with write_done=1.
- READ_ISSUE:
  - Lasts WORDS cycles. In cycle i (i = 0..WORDS-1): sram_en=1, sram_we=0, sram_addr = latched_addr + i, computed modulo 2^ADDR_SIZE (wraps at 0xFFFF -> 0x0000).
  - sram_rdata is captured one cycle after each issue into word slot i of mem_read_data.
  - After beat WORDS-1 is issued, go to READ_DRAIN.
- READ_DRAIN: one cycle; capture the last word; sram_en=0. Then go to DONE with read_valid=1.
- DONE: one cycle; exactly one of read_valid or write_done is high; request inputs are ignored. Then go to IDLE.
- Latency, with acceptance at the end of IDLE cycle T:
  - Write: SRAM write in cycle T+1; write_done high in T+2.
  - Read: issues in T+1..T+WORDS; read_valid high in T+WORDS+2 (T+18 at defaults).
  - The next acceptance is possible in T+3 (write) or T+WORDS+3 (read).
- Handshake: the requester deasserts en in the cycle after the pulse. If en is still high in the following IDLE cycle, that is a new request and is served again.
- mem_read_data: overwritten slot by slot during a read; guaranteed correct only while read_valid=1. It holds its value from read_valid until the first capture of the next read and is unaffected by writes.
- sram_en is 0 in IDLE and DONE. There is never more than one SRAM access per cycle.
- Reset mid-operation: the in-flight request is abandoned. In the cycle after rst is sampled, sram_en=0 and no read_valid or write_done is produced for that request. A partially written SRAM word is not possible because a write occupies a single cycle.
- Fixed width rules: WRITE_DATA_SIZE == WORD_SIZE and READ_DATA_SIZE % WORD_SIZE == 0. Any violation is an elaboration-time error.

Test Plan:
- Write 0xDEADBEEF to address 0x0010, en held until done -> sram_en=sram_we=1, sram_addr=0x0010, sram_wdata=0xDEADBEEF in T+1; write_done=1 for one cycle in T+2; SRAM word 0x0010 reads back 0xDEADBEEF.
- SRAM preloaded with word[a] = 0x10000000+a; read at 0x0000 -> sram_addr runs 0x0000..0x000F in T+1..T+16; read_valid=1 only in T+18; slot i = 0x10000000+i.
- Wrap: read at 0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007; slots 8..15 hold word[0x0000..0x0007].
- Simultaneous: read 0x0100 and write 0x0200 both asserted in cycle T -> write served (write_done in T+2); read accepted in T+3; read_valid in T+21 with the correct line.
- Reset mid-read: rst asserted for one cycle at T+5 of a read -> sram_en=0 and all outputs 0 next cycle; no read_valid ever for that read; a fresh read at 0x0040 after release completes in 18 cycles with correct data.
- Back-to-back: two reads at 0x0000 then 0x0020, en dropped one cycle after each pulse -> two read_valid pulses, 19+ cycles apart, each with the correct line; mem_read_data stable between the first pulse and the second read's first capture.
